// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_controller_pkg
// Shared definitions for the multi-cycle RV32I-subset control unit: opcode
// constants, FSM state encoding, ALU control codes, datapath mux select codes
// and the immediate-type decode helper.
// -----------------------------------------------------------------------------
package multicycle_controller_pkg;

    localparam int STATE_WIDTH    = 4;
    localparam int ALU_CTRL_WIDTH = 3;

    // Supported major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    // ALU control codes driven to the datapath ALU
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = 3'b101;

    // Operation class requested by the FSM; FUNCT defers to funct3/funct7
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // Datapath mux selects
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Bundle between the control unit and the shared datapath.
//   Datapath -> controller : opcode, funct3, funct7_5, zero, mem_ready
//   Controller -> datapath : pc_write, adr_src, mem_write, ir_write,
//                            result_src, alu_src_a, alu_src_b, imm_src,
//                            alu_control, reg_write, instr_retired,
//                            illegal_instr
// Modports: master = controller, slave = datapath side.
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
    import multicycle_controller_pkg::*;

    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic                      funct7_5;
    logic                      zero;
    logic                      mem_ready;

    logic                      pc_write;
    logic                      adr_src;
    logic                      mem_write;
    logic                      ir_write;
    logic [1:0]                result_src;
    logic [1:0]                alu_src_a;
    logic [1:0]                alu_src_b;
    logic [1:0]                imm_src;
    logic [ALU_CTRL_WIDTH-1:0] alu_control;
    logic                      reg_write;
    logic                      instr_retired;
    logic                      illegal_instr;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, reg_write,
               instr_retired, illegal_instr
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, reg_write,
               instr_retired, illegal_instr
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// -----------------------------------------------------------------------------
// multicycle_controller_alu_decoder
// Combinational ALU decoder.
//   alu_op_i      in  operation class from the FSM
//   funct3_i      in  instr[14:12]
//   funct7_5_i    in  instr[30]
//   op5_i         in  opcode[5] (1 = R-type, 0 = I-type)
//   alu_control_o out ALU operation code
//   f3_legal_o    out funct3 is one this core implements for R/I ALU ops
// -----------------------------------------------------------------------------
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  alu_op_e                   alu_op_i,
    input  logic [2:0]                funct3_i,
    input  logic                      funct7_5_i,
    input  logic                      op5_i,
    output logic [ALU_CTRL_WIDTH-1:0] alu_control_o,
    output logic                      f3_legal_o
);

    // Legality depends on funct3 alone so DECODE can use it before the
    // FSM requests a funct-driven operation.
    always_comb begin
        f3_legal_o = 1'b0;
        case (funct3_i)
            3'b000, 3'b010, 3'b110, 3'b111: f3_legal_o = 1'b1;
            default:                        f3_legal_o = 1'b0;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // instr[30] is part of the immediate for I-type, so it
                    // selects sub only for register-register ops.
                    3'b000:  alu_control_o = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM for a multi-cycle RV32I-subset core (lw, sw, R-type, I-type ALU,
// beq, jal) sharing one memory port between fetch and data access.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    master modport of multicycle_controller_if (decode inputs in,
//          mux selects / strobes / alu_control / status out)
// Optional feature: define MEM_WAIT_EN to hold FETCH, MEMREAD and MEMWRITE
// until mem_ready is high; otherwise every memory state takes one cycle.
// -----------------------------------------------------------------------------
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);

    state_e  state_q, state_d;
    logic    illegal_q, illegal_d;
    alu_op_e alu_op;
    logic    f3_legal;
    logic    mem_done;

    logic    pc_write, mem_write, ir_write, reg_write, retired;

`ifdef MEM_WAIT_EN
    assign mem_done = bus.mem_ready;
`else
    logic    mem_ready_unused;
    assign mem_done         = 1'b1;
    assign mem_ready_unused = bus.mem_ready;
`endif

    multicycle_controller_alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (bus.funct3),
        .funct7_5_i    (bus.funct7_5),
        .op5_i         (bus.opcode[5]),
        .alu_control_o (bus.alu_control),
        .f3_legal_o    (f3_legal)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Sticky: set on entry to TRAP, only reset clears it.
    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_comb begin
        state_d        = state_q;
        pc_write       = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        reg_write      = 1'b0;
        retired        = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = RES_ALUOUT;
        bus.alu_src_a  = SRC_A_PC;
        bus.alu_src_b  = SRC_B_RS2;
        alu_op         = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                // pc <= pc + 4 on the same edge that loads the IR
                bus.alu_src_b  = SRC_B_FOUR;
                bus.result_src = RES_ALU;
                ir_write       = mem_done;
                pc_write       = mem_done;
                if (mem_done) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch/jump target into alu_out
                bus.alu_src_a = SRC_A_OLDPC;
                bus.alu_src_b = SRC_B_IMM;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = (bus.funct3 == 3'b010) ? S_MEMADR : S_TRAP;
                    OP_R:              state_d = f3_legal ? S_EXECUTER : S_TRAP;
                    OP_I:              state_d = f3_legal ? S_EXECUTEI : S_TRAP;
                    OP_BRANCH:         state_d = (bus.funct3 == 3'b000) ? S_BEQ : S_TRAP;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_src_b = SRC_B_IMM;
                state_d       = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.adr_src = 1'b1;
                if (mem_done) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.result_src = RES_DATA;
                reg_write      = 1'b1;
                retired        = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.adr_src = 1'b1;
                mem_write   = 1'b1;
                retired     = mem_done;
                if (mem_done) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                bus.alu_src_a = SRC_A_RS1;
                alu_op        = ALUOP_FUNCT;
                state_d       = S_ALUWB;
            end
            S_EXECUTEI: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_src_b = SRC_B_IMM;
                alu_op        = ALUOP_FUNCT;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retired   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                // Target sits in alu_out from DECODE; take it when rs1 == rs2
                bus.alu_src_a = SRC_A_RS1;
                alu_op        = ALUOP_SUB;
                pc_write      = bus.zero;
                retired       = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                // pc <= target (alu_out) while old_pc + 4 lands in alu_out for rd
                bus.alu_src_a = SRC_A_OLDPC;
                bus.alu_src_b = SRC_B_FOUR;
                pc_write      = 1'b1;
                state_d       = S_ALUWB;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are masked by rst_n so nothing writes while reset is held,
    // even though the FETCH state itself would assert pc_write/ir_write.
    assign bus.pc_write      = rst_n & pc_write;
    assign bus.mem_write     = rst_n & mem_write;
    assign bus.ir_write      = rst_n & ir_write;
    assign bus.reg_write     = rst_n & reg_write;
    assign bus.instr_retired = rst_n & retired;
    assign bus.illegal_instr = illegal_q;
    assign bus.imm_src       = imm_src_of(bus.opcode);

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Directed bench for multicycle_controller. Strobes are packed as
// {pc_write, adr_src, mem_write, ir_write, reg_write, instr_retired};
// datapath fields as {alu_control, alu_src_a, alu_src_b, result_src}.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    localparam logic [8:0] M_ALU = 9'b111_00_00_00;
    localparam logic [8:0] M_AB  = 9'b000_11_11_00;
    localparam logic [8:0] M_RS  = 9'b000_00_00_11;
    localparam logic [8:0] M_ALL = 9'b111_11_11_11;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                bus.reg_write, bus.instr_retired};
    endfunction

    function automatic logic [8:0] dp_fields();
        return {bus.alu_control, bus.alu_src_a, bus.alu_src_b, bus.result_src};
    endfunction

    // Starts on a negedge while the DUT is in FETCH. Checks the strobe
    // vector every cycle and the masked datapath fields in cycle chk_c.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int n,
                             input logic [29:0] exp_strb, input int chk_c,
                             input logic [8:0] exp_dp, input logic [8:0] mask);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
        bus.zero     = z;
        for (int c = 1; c <= n; c++) begin
            #1;
            check($sformatf("%s c%0d strobes", name, c), 32'(strobes()),
                  32'(exp_strb[29-6*(c-1) -: 6]));
            if (c == chk_c)
                check($sformatf("%s c%0d datapath", name, c), 32'(dp_fields() & mask),
                      32'(exp_dp & mask));
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset strobes", 32'(strobes()), 32'h0);
        check("reset illegal", 32'(bus.illegal_instr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = OP_LOAD;
        bus.funct3    = 3'b010;
        bus.funct7_5  = 1'b0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset strobes", 32'(strobes()), 32'h0);
        check("reset illegal", 32'(bus.illegal_instr), 32'h0);
        check("reset selects", 32'(dp_fields()), 32'(9'b000_00_10_10));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("fetch selects", 32'(dp_fields()), 32'(9'b000_00_10_10));
        @(negedge clk);
        // One FETCH cycle was consumed above; the next negedge is DECODE of lw.
        // Re-align: reset again so every instruction starts cleanly in FETCH.
        do_reset();

        run_instr("lw", OP_LOAD, 3'b010, 1'b0, 1'b0, 5,
                  {6'b100100, 6'b000000, 6'b000000, 6'b010000, 6'b000011},
                  5, 9'b000_00_00_01, M_RS);
        run_instr("sw", OP_STORE, 3'b010, 1'b0, 1'b0, 4,
                  {6'b100100, 6'b000000, 6'b000000, 6'b011001, 6'b000000},
                  3, 9'b000_10_01_00, M_ALU | M_AB);
        check("sw imm_src", 32'(bus.imm_src), 32'(2'b01));
        run_instr("r_sub", OP_R, 3'b000, 1'b1, 1'b0, 4,
                  {6'b100100, 6'b000000, 6'b000000, 6'b000011, 6'b000000},
                  3, 9'b001_10_00_00, M_ALU | M_AB);
        run_instr("r_add", OP_R, 3'b000, 1'b0, 1'b0, 4,
                  {6'b100100, 6'b000000, 6'b000000, 6'b000011, 6'b000000},
                  3, 9'b000_10_00_00, M_ALU | M_AB);
        run_instr("r_or", OP_R, 3'b110, 1'b0, 1'b0, 4,
                  {6'b100100, 6'b000000, 6'b000000, 6'b000011, 6'b000000},
                  3, 9'b011_10_00_00, M_ALU | M_AB);
        run_instr("r_and", OP_R, 3'b111, 1'b0, 1'b0, 4,
                  {6'b100100, 6'b000000, 6'b000000, 6'b000011, 6'b000000},
                  3, 9'b010_10_00_00, M_ALU | M_AB);
        run_instr("i_slt", OP_I, 3'b010, 1'b0, 1'b0, 4,
                  {6'b100100, 6'b000000, 6'b000000, 6'b000011, 6'b000000},
                  3, 9'b101_10_01_00, M_ALU | M_AB);
        run_instr("i_add_f7", OP_I, 3'b000, 1'b1, 1'b0, 4,
                  {6'b100100, 6'b000000, 6'b000000, 6'b000011, 6'b000000},
                  3, 9'b000_10_01_00, M_ALU | M_AB);
        check("i imm_src", 32'(bus.imm_src), 32'(2'b00));
        run_instr("beq_taken", OP_BRANCH, 3'b000, 1'b0, 1'b1, 3,
                  {6'b100100, 6'b000000, 6'b100001, 6'b000000, 6'b000000},
                  3, 9'b001_10_00_00, M_ALL);
        run_instr("beq_not", OP_BRANCH, 3'b000, 1'b0, 1'b0, 3,
                  {6'b100100, 6'b000000, 6'b000001, 6'b000000, 6'b000000},
                  3, 9'b001_10_00_00, M_ALL);
        check("beq imm_src", 32'(bus.imm_src), 32'(2'b10));
        run_instr("jal", OP_JAL, 3'b101, 1'b0, 1'b0, 4,
                  {6'b100100, 6'b000000, 6'b100000, 6'b000011, 6'b000000},
                  3, 9'b000_01_10_00, M_ALL);
        check("jal imm_src", 32'(bus.imm_src), 32'(2'b11));
        check("no trap yet", 32'(bus.illegal_instr), 32'h0);

        // Reset asserted in the middle of MEMWRITE
        run_instr("sw_pre", OP_STORE, 3'b010, 1'b0, 1'b0, 3,
                  {6'b100100, 6'b000000, 6'b000000, 6'b000000, 6'b000000},
                  0, 9'h0, M_ALL);
        #1;
        check("memwrite before reset", 32'(bus.mem_write), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid reset strobes", 32'(strobes()), 32'h0);
        check("mid reset selects", 32'(dp_fields()), 32'(9'b000_00_10_10));
        check("mid reset illegal", 32'(bus.illegal_instr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr("lw_after_reset", OP_LOAD, 3'b010, 1'b0, 1'b0, 5,
                  {6'b100100, 6'b000000, 6'b000000, 6'b010000, 6'b000011},
                  0, 9'h0, M_ALL);

        // Unsupported funct3 on an R-type traps at DECODE
        run_instr("r_f3_bad", OP_R, 3'b001, 1'b0, 1'b0, 2,
                  {6'b100100, 6'b000000, 6'b000000, 6'b000000, 6'b000000},
                  0, 9'h0, M_ALL);
        #1;
        check("r_f3_bad illegal", 32'(bus.illegal_instr), 32'h1);
        check("r_f3_bad strobes", 32'(strobes()), 32'h0);
        @(negedge clk);

        // Unknown opcode: trapped for 20 cycles
        do_reset();
        run_instr("op7f", 7'b1111111, 3'b000, 1'b0, 1'b0, 2,
                  {6'b100100, 6'b000000, 6'b000000, 6'b000000, 6'b000000},
                  0, 9'h0, M_ALL);
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("trap c%0d strobes", i), 32'(strobes()), 32'h0);
            check($sformatf("trap c%0d illegal", i), 32'(bus.illegal_instr), 32'h1);
            @(negedge clk);
        end

        do_reset();
`ifdef MEM_WAIT_EN
        // FETCH stalls three cycles, then the fetch strobes pulse once
        bus.mem_ready = 1'b0;
        bus.opcode    = OP_R;
        bus.funct3    = 3'b000;
        for (int c = 1; c <= 3; c++) begin
            #1;
            check($sformatf("wait fetch c%0d strobes", c), 32'(strobes()), 32'h0);
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        run_instr("wait_r_add", OP_R, 3'b000, 1'b0, 1'b0, 4,
                  {6'b100100, 6'b000000, 6'b000000, 6'b000011, 6'b000000},
                  3, 9'b000_10_00_00, M_ALU | M_AB);
        // MEMWRITE stalls two cycles with mem_write held, retire on exit
        run_instr("wait_sw_pre", OP_STORE, 3'b010, 1'b0, 1'b0, 3,
                  {6'b100100, 6'b000000, 6'b000000, 6'b000000, 6'b000000},
                  0, 9'h0, M_ALL);
        bus.mem_ready = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            check($sformatf("wait memwrite c%0d strobes", c), 32'(strobes()), 32'(6'b011000));
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        #1;
        check("wait memwrite exit strobes", 32'(strobes()), 32'(6'b011001));
        @(negedge clk);
        #1;
        check("wait back to fetch", 32'(strobes()), 32'(6'b100100));
`else
        // mem_ready is ignored: timing identical with it held low
        bus.mem_ready = 1'b0;
        run_instr("nowait_lw", OP_LOAD, 3'b010, 1'b0, 1'b0, 5,
                  {6'b100100, 6'b000000, 6'b000000, 6'b010000, 6'b000011},
                  0, 9'h0, M_ALL);
        run_instr("nowait_sw", OP_STORE, 3'b010, 1'b0, 1'b0, 4,
                  {6'b100100, 6'b000000, 6'b000000, 6'b011001, 6'b000000},
                  0, 9'h0, M_ALL);
        #1;
        check("nowait back to fetch", 32'(strobes()), 32'(6'b100100));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
